// File: rtl/uart_mul_sequencer.sv
// uart_mul_sequencer
//   Protocol controller between the UART receiver, a multi-cycle 8x8
//   multiplier and the UART transmitter. It collects operand A and operand B
//   from the RX byte stream, launches the multiplier with a one-cycle pulse,
//   and returns the 16-bit product as two TX bytes, high byte first.
//   A framing error or an inter-byte timeout drops the partial request and
//   sets a sticky error flag, so the next byte is always treated as operand A.
//
// Ports
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   rx_data_i/valid_i/error_i     received byte, its valid and framing error
//   rx_ready_o                    byte accepted when rx_valid_i & rx_ready_o
//   mul_a_o, mul_b_o              registered operands to the multiplier
//   mul_start_o                   one-cycle multiplier launch pulse
//   mul_done_i, mul_product_i     multiplier completion pulse and product
//   tx_data_o/valid_o, tx_ready_i byte to transmit, valid/ready handshake
//   busy_o                        request in progress (not IDLE)
//   error_o                       sticky error, cleared by the next clean A
module uart_mul_sequencer #(
    parameter int unsigned TimeoutCycles = 120_000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    input  logic        rx_error_i,
    output logic        rx_ready_o,
    output logic [7:0]  mul_a_o,
    output logic [7:0]  mul_b_o,
    output logic        mul_start_o,
    input  logic        mul_done_i,
    input  logic [15:0] mul_product_i,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic        busy_o,
    output logic        error_o
);

    localparam int unsigned CntW = $clog2(TimeoutCycles);
    localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_B,
        START,
        WAIT_MUL,
        SEND_HI,
        SEND_LO
    } state_e;

    state_e          state_q, state_d;
    logic [7:0]      a_q, a_d;
    logic [7:0]      b_q, b_d;
    logic [15:0]     result_q, result_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;
    logic            rx_accept;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    // All handshake outputs decode directly from the state register, so an
    // asynchronous reset drops tx_valid_o/busy_o without waiting for a clock.
    always_comb begin
        rx_ready_o  = (state_q == IDLE) || (state_q == WAIT_B);
        mul_start_o = (state_q == START);
        tx_valid_o  = (state_q == SEND_HI) || (state_q == SEND_LO);
        busy_o      = (state_q != IDLE);
        tx_data_o   = 8'h00;
        if (state_q == SEND_HI) begin
            tx_data_o = result_q[15:8];
        end else if (state_q == SEND_LO) begin
            tx_data_o = result_q[7:0];
        end
    end

    assign rx_accept = rx_valid_i & rx_ready_o;
    assign mul_a_o   = a_q;
    assign mul_b_o   = b_q;
    assign error_o   = err_q;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        unique case (state_q)
            IDLE: begin
                if (rx_accept) begin
                    if (rx_error_i) begin
                        err_d = 1'b1;
                    end else begin
                        a_d     = rx_data_i;
                        err_d   = 1'b0;
                        cnt_d   = '0;
                        state_d = WAIT_B;
                    end
                end
            end
            WAIT_B: begin
                // An accept on the expiry cycle takes priority over the timeout.
                if (rx_accept) begin
                    if (rx_error_i) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        b_d     = rx_data_i;
                        state_d = START;
                    end
                end else if (cnt_q == CntLast) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            START: begin
                state_d = WAIT_MUL;
            end
            WAIT_MUL: begin
                if (mul_done_i) begin
                    result_d = mul_product_i;
                    state_d  = SEND_HI;
                end
            end
            SEND_HI: begin
                if (tx_ready_i) begin
                    state_d = SEND_LO;
                end
            end
            SEND_LO: begin
                if (tx_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_mul_sequencer.sv
// Self-checking bench for uart_mul_sequencer: directed scenarios followed by
// randomized requests. A request-level model predicts multiplier launches,
// TX bytes and the error flag; a monitor compares DUT outputs as they appear.
module tb_uart_mul_sequencer;

    localparam int T = 16;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b1;
    logic [7:0]  rx_data_i = 8'h00;
    logic        rx_valid_i = 1'b0;
    logic        rx_error_i = 1'b0;
    logic        rx_ready_o;
    logic [7:0]  mul_a_o, mul_b_o;
    logic        mul_start_o;
    logic        mul_done_i;
    logic [15:0] mul_product_i;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i;
    logic        busy_o, error_o;

    // environment drivers
    logic        mdl_done = 1'b0, spur_done = 1'b0;
    logic [15:0] mdl_prod = 16'h0, spur_prod = 16'h0;
    logic        rand_ready = 1'b0, rnd_ready = 1'b1, fixed_ready = 1'b1;
    int          mul_lat = 8;

    assign mul_done_i    = mdl_done | spur_done;
    assign mul_product_i = mdl_done ? mdl_prod : spur_prod;
    assign tx_ready_i    = rand_ready ? rnd_ready : fixed_ready;

    uart_mul_sequencer #(.TimeoutCycles(T)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_error_i(rx_error_i),
        .rx_ready_o(rx_ready_o),
        .mul_a_o(mul_a_o), .mul_b_o(mul_b_o), .mul_start_o(mul_start_o),
        .mul_done_i(mul_done_i), .mul_product_i(mul_product_i),
        .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
        .busy_o(busy_o), .error_o(error_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // ---------------- reference model (request level) ----------------
    logic [7:0]  exp_tx[$];
    logic [15:0] exp_start[$];
    logic        have_a = 1'b0;
    logic [7:0]  mdl_a = 8'h00;
    logic        exp_err = 1'b0;

    task automatic model_accept(input logic [7:0] d, input logic e, output logic starts);
        logic [15:0] p;
        starts = 1'b0;
        if (!have_a) begin
            if (e) exp_err = 1'b1;
            else begin
                have_a = 1'b1; mdl_a = d; exp_err = 1'b0;
            end
        end else begin
            have_a = 1'b0;
            if (e) exp_err = 1'b1;
            else begin
                p = 16'(mdl_a) * 16'(d);
                exp_start.push_back({mdl_a, d});
                exp_tx.push_back(p[15:8]);
                exp_tx.push_back(p[7:0]);
                starts = 1'b1;
            end
        end
    endtask

    task automatic model_reset();
        exp_tx.delete();
        exp_start.delete();
        have_a = 1'b0;
        exp_err = 1'b0;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic send_byte(input logic [7:0] d, input logic e);
        int   guard = 0;
        logic starts;
        @(negedge clk_i);
        rx_data_i = d; rx_error_i = e; rx_valid_i = 1'b1;
        while (!rx_ready_o && guard < 1000) begin
            @(negedge clk_i);
            guard++;
        end
        if (!rx_ready_o) begin
            check("rx_accept_wait", 32'(rx_ready_o), 32'd1);
            rx_valid_i = 1'b0;
            return;
        end
        @(posedge clk_i);
        #1 rx_valid_i = 1'b0; rx_error_i = 1'b0;
        model_accept(d, e, starts);
        @(negedge clk_i);
        check("error_after_rx", 32'(error_o), 32'(exp_err));
        if (starts) check("start_after_b", 32'(mul_start_o), 32'd1);
    endtask

    // Idle g cycles after operand A. B presented afterwards is accepted g+1
    // edges after A, so it is honoured only while g+1 <= T.
    task automatic gap(input int g);
        repeat (g) @(posedge clk_i);
        #1;
        if (have_a && g >= T) begin
            have_a = 1'b0;
            exp_err = 1'b1;
            check("timeout_idle", 32'(busy_o), 32'd0);
        end
        check("error_after_gap", 32'(error_o), 32'(exp_err));
    endtask

    task automatic set_ready(input logic rnd, input logic val);
        @(posedge clk_i);
        #1 rand_ready = rnd; fixed_ready = val;
    endtask

    task automatic wait_tx_valid();
        int g = 0;
        while (!tx_valid_o && g < 300) begin
            @(negedge clk_i);
            g++;
        end
        check("tx_valid_wait", 32'(tx_valid_o), 32'd1);
    endtask

    task automatic drain();
        int g = 0;
        while ((exp_tx.size() != 0 || busy_o) && g < 600) begin
            @(negedge clk_i);
            g++;
        end
        check("drain", 32'(exp_tx.size() == 0 && !busy_o), 32'd1);
    endtask

    task automatic request(input logic [7:0] a, input logic [7:0] b);
        send_byte(a, 1'b0);
        send_byte(b, 1'b0);
        drain();
        check("error_after_req", 32'(error_o), 32'(exp_err));
    endtask

    // random TX readiness, changed just after the active edge
    initial forever begin
        @(posedge clk_i);
        #1 rnd_ready = 1'($urandom_range(0, 1));
    end

    // multiplier model with mul_lat cycles spent in WAIT_MUL
    initial forever begin
        logic [15:0] p;
        @(negedge clk_i);
        if (rst_ni && mul_start_o) begin
            p = 16'(mul_a_o) * 16'(mul_b_o);
            repeat (mul_lat) @(negedge clk_i);
            mdl_prod = p;
            mdl_done = 1'b1;
            @(negedge clk_i);
            mdl_done = 1'b0;
            check("done_to_tx_valid", 32'(tx_valid_o), 32'd1);
            check("done_to_tx_hi", 32'(tx_data_o), 32'(p[15:8]));
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic       prev_v, prev_r, chk_ready;
        logic [7:0] prev_d;
        logic [15:0] s;
        logic [7:0] e;
        prev_v = 1'b0; prev_r = 1'b0; prev_d = 8'h00; chk_ready = 1'b0;
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                prev_v = 1'b0;
                chk_ready = 1'b0;
                continue;
            end
            if (chk_ready) begin
                check("rx_ready_after_lo", 32'(rx_ready_o), 32'd1);
                chk_ready = 1'b0;
            end
            if (prev_v && !prev_r) begin
                check("tx_hold_valid", 32'(tx_valid_o), 32'd1);
                check("tx_hold_data", 32'(tx_data_o), 32'(prev_d));
            end
            if (tx_valid_o) check("rx_ready_during_tx", 32'(rx_ready_o), 32'd0);
            if (mul_start_o) begin
                if (exp_start.size() == 0) check("unexpected_start", 32'(mul_start_o), 32'd0);
                else begin
                    s = exp_start.pop_front();
                    check("start_operands", 32'({mul_a_o, mul_b_o}), 32'(s));
                end
            end
            if (tx_valid_o && tx_ready_i) begin
                if (exp_tx.size() == 0) check("unexpected_tx", 32'(tx_valid_o), 32'd0);
                else begin
                    e = exp_tx.pop_front();
                    check("tx_byte", 32'(tx_data_o), 32'(e));
                    $display("tx byte %02h expected %02h", tx_data_o, e);
                    if (exp_tx.size() == 0) chk_ready = 1'b1;
                end
            end
            prev_v = tx_valid_o; prev_r = tx_ready_i; prev_d = tx_data_o;
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        #1 rst_ni = 1'b0;
        #2;
        check("rst_rx_ready", 32'(rx_ready_o), 32'd1);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_tx_valid", 32'(tx_valid_o), 32'd0);
        check("rst_tx_data", 32'(tx_data_o), 32'd0);
        check("rst_start", 32'(mul_start_o), 32'd0);
        check("rst_error", 32'(error_o), 32'd0);
        check("rst_ab", 32'({mul_a_o, mul_b_o}), 32'd0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        check("post_rst_rx_ready", 32'(rx_ready_o), 32'd1);

        // basic product, D = 8, always-ready TX
        mul_lat = 8;
        request(8'h0C, 8'h0B);

        // TX stall of 20 cycles on 0xFE
        set_ready(1'b0, 1'b0);
        send_byte(8'hFF, 1'b0);
        send_byte(8'hFF, 1'b0);
        wait_tx_valid();
        repeat (20) @(negedge clk_i);
        check("stall_hi_byte", 32'(tx_data_o), 32'hFE);
        set_ready(1'b0, 1'b1);
        drain();

        // framing error on B, then a clean request clears the flag
        send_byte(8'h12, 1'b0);
        send_byte(8'h99, 1'b1);
        check("err_b_idle", 32'(busy_o), 32'd0);
        request(8'h03, 8'h05);

        // framing error on A stays in IDLE
        send_byte(8'h44, 1'b1);
        check("err_a_idle", 32'(busy_o), 32'd0);

        // timeout, then B exactly on the expiry cycle
        send_byte(8'h07, 1'b0);
        gap(T);
        request(8'h02, 8'h02);
        send_byte(8'h07, 1'b0);
        gap(T - 1);
        send_byte(8'h02, 1'b0);
        drain();
        check("expiry_b_error", 32'(error_o), 32'd0);

        // spurious mul_done in IDLE and WAIT_B
        @(negedge clk_i);
        spur_prod = 16'hBEEF; spur_done = 1'b1;
        @(negedge clk_i);
        spur_done = 1'b0;
        check("spur_idle_busy", 32'(busy_o), 32'd0);
        check("spur_idle_tx", 32'(tx_valid_o), 32'd0);
        send_byte(8'h09, 1'b0);
        spur_done = 1'b1;
        @(negedge clk_i);
        spur_done = 1'b0;
        check("spur_waitb_busy", 32'(busy_o), 32'd1);
        check("spur_waitb_ready", 32'(rx_ready_o), 32'd1);
        send_byte(8'h0A, 1'b0);
        drain();

        // asynchronous reset while the high byte is waiting
        set_ready(1'b0, 1'b0);
        send_byte(8'hA5, 1'b0);
        send_byte(8'h3C, 1'b0);
        wait_tx_valid();
        #2 rst_ni = 1'b0;
        #1;
        check("async_rst_tx_valid", 32'(tx_valid_o), 32'd0);
        check("async_rst_busy", 32'(busy_o), 32'd0);
        check("async_rst_rx_ready", 32'(rx_ready_o), 32'd1);
        model_reset();
        repeat (3) @(negedge clk_i);
        check("rst_hold_tx_valid", 32'(tx_valid_o), 32'd0);
        rst_ni = 1'b1;
        set_ready(1'b0, 1'b1);
        request(8'h21, 8'h13);

        // randomized requests with errors, gaps and TX backpressure
        set_ready(1'b1, 1'b1);
        for (int it = 0; it < 40; it++) begin
            mul_lat = int'($urandom_range(1, 12));
            send_byte(8'($urandom), ($urandom_range(0, 9) == 0));
            if (have_a && $urandom_range(0, 1) == 1) gap(int'($urandom_range(1, 20)));
            send_byte(8'($urandom), ($urandom_range(0, 9) == 0));
        end
        if (have_a) send_byte(8'($urandom), 1'b0);
        drain();
        set_ready(1'b0, 1'b1);
        check("final_idle", 32'(busy_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=running expected=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
